branch_tag_manager: RTL and testbench

Allocates, tracks and reclaims branch tags (branch_id plus color_bit) for in-flight branches. Sits between decode, which tags each decoded branch, and the hazard controller's `hazard_signals_ifc` output, which reports resolution. On a misprediction it computes and broadcasts a one-cycle squash mask of all younger tags so the issue queue and rename checkpoints can discard wrong-path state. Tags are allocated in program order from a circular pool; the color bit disambiguates wrap-around.

---
 rtl/mips_core_pkg.sv | 18 +
 rtl/tag_range_mask.sv | 25 ++
 rtl/branch_tag_manager.sv | 129 ++++++++++++
 tb/tb_branch_tag_manager.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared types and defaults for the branch tag pool: tag struct, pool size, and
// the recovery FSM state encoding.
package mips_core_pkg;

    localparam int DEFAULT_NUM_TAGS = 8;
    localparam int DEFAULT_TAG_W    = $clog2(DEFAULT_NUM_TAGS);

    typedef struct packed {
        logic [DEFAULT_TAG_W-1:0] id;
        logic                     color;
    } branch_tag_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } tag_fsm_e;

endpackage

// File: rtl/tag_range_mask.sv
// Circular range mask over the tag pool: bit i is set when i lies in [start, end)
// going upward with wrap-around. An equal start and end gives an empty mask.
module tag_range_mask
    import mips_core_pkg::*;
#(
    parameter int NUM_TAGS = DEFAULT_NUM_TAGS,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic [TAG_W-1:0]    i_start,
    input  logic [TAG_W-1:0]    i_end,
    output logic [NUM_TAGS-1:0] o_mask
);

    logic [TAG_W-1:0] w_len;

    assign w_len = i_end - i_start;

    always_comb begin
        o_mask = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            o_mask[i] = (TAG_W'(i) - i_start) < w_len;
        end
    end

endmodule

// File: rtl/branch_tag_manager.sv
// Circular branch tag pool: allocates tags to decode in program order, tracks
// resolution, retires from the head and broadcasts a squash mask on misprediction.
module branch_tag_manager
    import mips_core_pkg::*;
#(
    parameter int NUM_TAGS = DEFAULT_NUM_TAGS,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_alloc_req,
    output logic                o_alloc_gnt,
    output logic [TAG_W-1:0]    o_alloc_id,
    output logic                o_alloc_color,
    input  logic                i_resolve_valid,
    input  logic [TAG_W-1:0]    i_resolve_id,
    input  logic                i_resolve_color,
    input  logic                i_resolve_miss,
    output logic                o_squash_valid,
    output logic [NUM_TAGS-1:0] o_squash_mask,
    output logic                o_recover_busy,
    output logic [TAG_W:0]      o_outstanding,
    output logic                o_full,
    output logic                o_empty
);

    logic [NUM_TAGS-1:0] r_valid;
    logic [NUM_TAGS-1:0] r_resolved;
    logic [NUM_TAGS-1:0] r_color;
    logic [TAG_W:0]      r_head;
    logic [TAG_W:0]      r_tail;
    tag_fsm_e            r_state;
    logic                r_squash_valid;
    logic [NUM_TAGS-1:0] r_squash_mask;

    logic [TAG_W-1:0]    w_head_idx;
    logic [TAG_W-1:0]    w_tail_idx;
    logic                w_full;
    logic                w_res_ok;
    logic                w_miss;
    logic                w_retire;
    logic                w_gnt;
    logic [TAG_W-1:0]    w_kill_start;
    logic [NUM_TAGS-1:0] w_kill_mask;
    logic [TAG_W:0]      w_miss_tail;
    logic [NUM_TAGS-1:0] w_valid_nxt;

    assign w_head_idx = r_head[TAG_W-1:0];
    assign w_tail_idx = r_tail[TAG_W-1:0];
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);

    // A resolve only counts if it names the live occupant of the slot; the color
    // rejects resolves for a tag generation that has already been reclaimed.
    assign w_res_ok = i_resolve_valid && r_valid[i_resolve_id]
                      && (r_color[i_resolve_id] == i_resolve_color);
    assign w_miss   = w_res_ok && i_resolve_miss;
    assign w_retire = r_valid[w_head_idx] && r_resolved[w_head_idx];

    // Any miss on the bus withholds the grant, stale or not, to keep this path short.
    assign w_gnt = i_alloc_req && !w_full && (r_state == NORMAL)
                   && !(i_resolve_valid && i_resolve_miss);

    assign w_kill_start = i_resolve_id + TAG_W'(1);
    assign w_miss_tail  = {i_resolve_color, i_resolve_id} + (TAG_W+1)'(1);

    tag_range_mask #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_kill_mask (
        .i_start (w_kill_start),
        .i_end   (w_tail_idx),
        .o_mask  (w_kill_mask)
    );

    // Retire, allocate and kill touch disjoint slots; allocate and kill never coincide.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_retire) w_valid_nxt[w_head_idx] = 1'b0;
        if (w_gnt)    w_valid_nxt[w_tail_idx] = 1'b1;
        if (w_miss)   w_valid_nxt = w_valid_nxt & ~w_kill_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_resolved <= '0;
            r_color    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_retire) r_head <= r_head + (TAG_W+1)'(1);
            if (w_gnt) begin
                r_resolved[w_tail_idx] <= 1'b0;
                r_color[w_tail_idx]    <= r_tail[TAG_W];
                r_tail                 <= r_tail + (TAG_W+1)'(1);
            end
            if (w_res_ok) r_resolved[i_resolve_id] <= 1'b1;
            if (w_miss)   r_tail <= w_miss_tail;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= NORMAL;
            r_squash_valid <= 1'b0;
            r_squash_mask  <= '0;
        end else begin
            r_squash_valid <= w_miss;
            r_squash_mask  <= w_miss ? w_kill_mask : '0;
            case (r_state)
                NORMAL:  r_state <= w_miss ? RECOVER : NORMAL;
                RECOVER: r_state <= w_miss ? RECOVER : NORMAL;
                default: r_state <= NORMAL;
            endcase
        end
    end

    assign o_alloc_gnt    = w_gnt;
    assign o_alloc_id     = w_tail_idx;
    assign o_alloc_color  = r_tail[TAG_W];
    assign o_squash_valid = r_squash_valid;
    assign o_squash_mask  = r_squash_mask;
    assign o_recover_busy = (r_state == RECOVER);
    assign o_outstanding  = r_tail - r_head;
    assign o_full         = w_full;
    assign o_empty        = (r_tail == r_head);

endmodule

// File: tb/tb_branch_tag_manager.sv
// Bench for branch_tag_manager: directed scenarios plus randomized traffic checked
// against a sequence-number model of the in-flight branch window.
module tb_branch_tag_manager;
    import mips_core_pkg::*;

    localparam int N = 8;

    logic       clk;
    logic       rst_n;
    logic       i_alloc_req;
    logic       o_alloc_gnt;
    logic [2:0] o_alloc_id;
    logic       o_alloc_color;
    logic       i_resolve_valid;
    logic [2:0] i_resolve_id;
    logic       i_resolve_color;
    logic       i_resolve_miss;
    logic       o_squash_valid;
    logic [7:0] o_squash_mask;
    logic       o_recover_busy;
    logic [3:0] o_outstanding;
    logic       o_full;
    logic       o_empty;

    int n_checks = 0;
    int n_errors = 0;

    // Model: branches numbered by program-order sequence; id = seq % N, color = (seq / N) % 2.
    int         m_head;
    int         m_tail;
    bit         m_q[$];
    bit         m_rec;
    bit         m_sq_v;
    logic [7:0] m_sq_mask;

    branch_tag_manager #(.NUM_TAGS(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_alloc_req     (i_alloc_req),
        .o_alloc_gnt     (o_alloc_gnt),
        .o_alloc_id      (o_alloc_id),
        .o_alloc_color   (o_alloc_color),
        .i_resolve_valid (i_resolve_valid),
        .i_resolve_id    (i_resolve_id),
        .i_resolve_color (i_resolve_color),
        .i_resolve_miss  (i_resolve_miss),
        .o_squash_valid  (o_squash_valid),
        .o_squash_mask   (o_squash_mask),
        .o_recover_busy  (o_recover_busy),
        .o_outstanding   (o_outstanding),
        .o_full          (o_full),
        .o_empty         (o_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_q.delete();
        m_rec = 0; m_sq_v = 0; m_sq_mask = '0;
    endtask

    function automatic bit exp_gnt();
        return i_alloc_req && ((m_tail - m_head) < N) && !m_rec
               && !(i_resolve_valid && i_resolve_miss);
    endfunction

    task automatic model_step();
        int  k;
        bit  g;
        bit  ret;
        bit  miss;
        logic [7:0] mask;
        k = -1;
        if (i_resolve_valid)
            for (int j = 0; j < m_q.size(); j++)
                if (((m_head + j) % N) == int'(i_resolve_id)
                    && (((m_head + j) / N) % 2) == int'(i_resolve_color)) k = j;
        g    = exp_gnt();
        ret  = (m_q.size() > 0) && m_q[0];
        miss = (k >= 0) && i_resolve_miss;
        mask = '0;
        if (k >= 0) m_q[k] = 1'b1;
        if (miss) begin
            for (int j = k + 1; j < m_q.size(); j++) mask[(m_head + j) % N] = 1'b1;
            while (m_q.size() > k + 1) void'(m_q.pop_back());
            m_tail = m_head + k + 1;
        end
        if (g) begin m_q.push_back(1'b0); m_tail++; end
        if (ret) begin void'(m_q.pop_front()); m_head++; end
        m_rec = miss; m_sq_v = miss; m_sq_mask = mask;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_alloc_req = 0; i_resolve_valid = 0; i_resolve_id = '0;
        i_resolve_color = 0; i_resolve_miss = 0;
    endtask

    task automatic set_resolve(input int id, input bit col, input bit miss);
        i_resolve_valid = 1; i_resolve_id = 3'(id); i_resolve_color = col; i_resolve_miss = miss;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_n(input int n);
        i_alloc_req = 1;
        for (int i = 0; i < n; i++) tick();
        i_alloc_req = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (o_alloc_id !== 3'd0) begin n_errors++; $display("FAIL reset_alloc_id got %0d exp 0", o_alloc_id); end
        n_checks++; if (o_alloc_color !== 1'b0) begin n_errors++; $display("FAIL reset_alloc_color got %0b exp 0", o_alloc_color); end
        n_checks++; if (o_squash_valid !== 1'b0 || o_squash_mask !== 8'h00) begin n_errors++; $display("FAIL reset_squash got %0b/%b exp 0/00000000", o_squash_valid, o_squash_mask); end
        n_checks++; if (o_recover_busy !== 1'b0) begin n_errors++; $display("FAIL reset_recover got %0b exp 0", o_recover_busy); end
        n_checks++; if (o_outstanding !== 4'd0 || o_full !== 1'b0 || o_empty !== 1'b1) begin n_errors++; $display("FAIL reset_occupancy got out=%0d full=%0b empty=%0b exp 0/0/1", o_outstanding, o_full, o_empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < N; i++) begin
            i_alloc_req = 1;
            #1;
            n_checks++; if (o_alloc_gnt !== 1'b1 || o_alloc_id !== 3'(i) || o_alloc_color !== 1'b0) begin n_errors++; $display("FAIL fill_alloc_%0d got gnt=%0b id=%0d col=%0b exp 1/%0d/0", i, o_alloc_gnt, o_alloc_id, o_alloc_color, i); end
            tick();
        end
        #1;
        n_checks++; if (o_full !== 1'b1 || o_outstanding !== 4'd8 || o_empty !== 1'b0) begin n_errors++; $display("FAIL fill_full got full=%0b out=%0d empty=%0b exp 1/8/0", o_full, o_outstanding, o_empty); end
        n_checks++; if (o_alloc_gnt !== 1'b0) begin n_errors++; $display("FAIL fill_ninth_gnt got %0b exp 0", o_alloc_gnt); end
        tick();
        i_alloc_req = 0;
        n_checks++; if (o_outstanding !== 4'd8) begin n_errors++; $display("FAIL fill_no_overflow got %0d exp 8", o_outstanding); end
    endtask

    task automatic test_resolve_order();
        int exp_out [3] = '{7, 6, 5};
        set_resolve(2, 0, 0); tick();
        set_resolve(1, 0, 0); tick();
        set_resolve(0, 0, 0); tick();
        idle_inputs();
        n_checks++; if (o_outstanding !== 4'd8) begin n_errors++; $display("FAIL ooo_before_retire got %0d exp 8", o_outstanding); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (o_outstanding !== 4'(exp_out[i])) begin n_errors++; $display("FAIL ooo_retire_%0d got %0d exp %0d", i, o_outstanding, exp_out[i]); end
        end
        tick();
        n_checks++; if (o_outstanding !== 4'd5) begin n_errors++; $display("FAIL ooo_stop_at_3 got %0d exp 5", o_outstanding); end
    endtask

    task automatic test_mispredict();
        apply_reset();
        alloc_n(6);
        set_resolve(2, 0, 1);
        i_alloc_req = 1;
        #1;
        n_checks++; if (o_alloc_gnt !== 1'b0) begin n_errors++; $display("FAIL miss_withholds_gnt got %0b exp 0", o_alloc_gnt); end
        tick();
        idle_inputs();
        n_checks++; if (o_squash_valid !== 1'b1 || o_squash_mask !== 8'b0011_1000) begin n_errors++; $display("FAIL miss_squash got %0b/%b exp 1/00111000", o_squash_valid, o_squash_mask); end
        n_checks++; if (o_recover_busy !== 1'b1) begin n_errors++; $display("FAIL miss_recover got %0b exp 1", o_recover_busy); end
        n_checks++; if (o_alloc_id !== 3'd3 || o_outstanding !== 4'd3) begin n_errors++; $display("FAIL miss_tail got id=%0d out=%0d exp 3/3", o_alloc_id, o_outstanding); end
        tick();
        n_checks++; if (o_squash_valid !== 1'b0 || o_squash_mask !== 8'h00 || o_recover_busy !== 1'b0) begin n_errors++; $display("FAIL miss_pulse_end got %0b/%b/%0b exp 0/00000000/0", o_squash_valid, o_squash_mask, o_recover_busy); end
    endtask

    task automatic test_wrap();
        int c;
        apply_reset();
        alloc_n(8);
        for (int j = 0; j < 7; j++) begin set_resolve(j, 0, 0); tick(); end
        idle_inputs();
        c = 0;
        while (c < 20 && o_outstanding !== 4'd1) begin tick(); c++; end
        n_checks++; if (o_outstanding !== 4'd1) begin n_errors++; $display("FAIL wrap_drain got %0d exp 1", o_outstanding); end
        i_alloc_req = 1;
        #1;
        n_checks++; if (o_alloc_gnt !== 1'b1 || o_alloc_id !== 3'd0 || o_alloc_color !== 1'b1) begin n_errors++; $display("FAIL wrap_alloc got gnt=%0b id=%0d col=%0b exp 1/0/1", o_alloc_gnt, o_alloc_id, o_alloc_color); end
        tick();
        i_alloc_req = 0;
        set_resolve(7, 0, 1);
        tick();
        idle_inputs();
        n_checks++; if (o_squash_valid !== 1'b1 || o_squash_mask !== 8'b0000_0001) begin n_errors++; $display("FAIL wrap_mask got %0b/%b exp 1/00000001", o_squash_valid, o_squash_mask); end
        n_checks++; if (o_alloc_id !== 3'd0 || o_alloc_color !== 1'b1 || o_outstanding !== 4'd1) begin n_errors++; $display("FAIL wrap_tail got id=%0d col=%0b out=%0d exp 0/1/1", o_alloc_id, o_alloc_color, o_outstanding); end
        tick();
        n_checks++; if (o_empty !== 1'b1 || o_outstanding !== 4'd0) begin n_errors++; $display("FAIL wrap_head_retire got empty=%0b out=%0d exp 1/0", o_empty, o_outstanding); end
    endtask

    task automatic test_stale_simul();
        alloc_n(5);
        set_resolve(4, 0, 1);
        i_alloc_req = 1;
        #1;
        n_checks++; if (o_alloc_gnt !== 1'b0) begin n_errors++; $display("FAIL stale_gnt got %0b exp 0", o_alloc_gnt); end
        tick();
        idle_inputs();
        n_checks++; if (o_squash_valid !== 1'b0 || o_recover_busy !== 1'b0 || o_outstanding !== 4'd5) begin n_errors++; $display("FAIL stale_ignored got sq=%0b rec=%0b out=%0d exp 0/0/5", o_squash_valid, o_recover_busy, o_outstanding); end
        set_resolve(1, 1, 1);
        i_alloc_req = 1;
        #1;
        n_checks++; if (o_alloc_gnt !== 1'b0) begin n_errors++; $display("FAIL simul_gnt got %0b exp 0", o_alloc_gnt); end
        tick();
        idle_inputs();
        n_checks++; if (o_squash_mask !== 8'b0001_1100 || o_outstanding !== 4'd2 || o_alloc_id !== 3'd2) begin n_errors++; $display("FAIL simul_miss got mask=%b out=%0d id=%0d exp 00011100/2/2", o_squash_mask, o_outstanding, o_alloc_id); end
    endtask

    task automatic test_random();
        branch_tag_t t;
        bit g;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_alloc_req = ($urandom_range(3) != 0);
            i_resolve_valid = $urandom_range(1);
            i_resolve_miss = ($urandom_range(5) == 0);
            if (m_q.size() > 0 && $urandom_range(2) != 0) begin
                int k;
                k = $urandom_range(m_q.size() - 1);
                t.id = 3'((m_head + k) % N);
                t.color = 1'(((m_head + k) / N) % 2);
                if ($urandom_range(3) == 0) t.color = ~t.color;
            end else begin
                t.id = 3'($urandom_range(N - 1));
                t.color = 1'($urandom_range(1));
            end
            i_resolve_id = t.id; i_resolve_color = t.color;
            #1;
            g = exp_gnt();
            n_checks++; if (o_alloc_gnt !== g) begin n_errors++; $display("FAIL rnd_gnt cyc %0d got %0b exp %0b", cyc, o_alloc_gnt, g); end
            n_checks++; if (o_alloc_id !== 3'(m_tail % N) || o_alloc_color !== 1'((m_tail / N) % 2)) begin n_errors++; $display("FAIL rnd_tail cyc %0d got %0d/%0b exp %0d/%0d", cyc, o_alloc_id, o_alloc_color, m_tail % N, (m_tail / N) % 2); end
            n_checks++; if (o_outstanding !== 4'(m_tail - m_head)) begin n_errors++; $display("FAIL rnd_outstanding cyc %0d got %0d exp %0d", cyc, o_outstanding, m_tail - m_head); end
            n_checks++; if (o_full !== ((m_tail - m_head) == N) || o_empty !== (m_tail == m_head)) begin n_errors++; $display("FAIL rnd_full_empty cyc %0d got %0b/%0b exp %0b/%0b", cyc, o_full, o_empty, (m_tail - m_head) == N, m_tail == m_head); end
            n_checks++; if (o_recover_busy !== m_rec) begin n_errors++; $display("FAIL rnd_recover cyc %0d got %0b exp %0b", cyc, o_recover_busy, m_rec); end
            n_checks++; if (o_squash_valid !== m_sq_v || o_squash_mask !== m_sq_mask) begin n_errors++; $display("FAIL rnd_squash cyc %0d got %0b/%b exp %0b/%b", cyc, o_squash_valid, o_squash_mask, m_sq_v, m_sq_mask); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        alloc_n(3);
        set_resolve(0, 0, 1);
        tick();
        idle_inputs();
        n_checks++; if (o_recover_busy !== 1'b1 || o_squash_valid !== 1'b1) begin n_errors++; $display("FAIL arst_setup got rec=%0b sq=%0b exp 1/1", o_recover_busy, o_squash_valid); end
        #1;
        rst_n = 0;
        #1;
        n_checks++; if (o_recover_busy !== 1'b0 || o_squash_valid !== 1'b0 || o_squash_mask !== 8'h00) begin n_errors++; $display("FAIL arst_fsm got rec=%0b sq=%0b mask=%b exp 0/0/00000000", o_recover_busy, o_squash_valid, o_squash_mask); end
        n_checks++; if (o_outstanding !== 4'd0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_alloc_id !== 3'd0 || o_alloc_color !== 1'b0) begin n_errors++; $display("FAIL arst_ptrs got out=%0d empty=%0b full=%0b id=%0d col=%0b exp 0/1/0/0/0", o_outstanding, o_empty, o_full, o_alloc_id, o_alloc_color); end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++; if (o_squash_valid !== 1'b0 || o_recover_busy !== 1'b0 || o_empty !== 1'b1) begin n_errors++; $display("FAIL arst_after got sq=%0b rec=%0b empty=%0b exp 0/0/1", o_squash_valid, o_recover_busy, o_empty); end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_fill();
        test_resolve_order();
        test_mispredict();
        test_wrap();
        test_stale_simul();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
